// File: rtl/io_input_capture.sv
// io_input_capture: synchronized, debounced buttons and switches behind a small CPU register window.
// Define IO_IRQ_EN to add the MASK register at +0xC and the registered irq output.
module io_input_capture #(
    parameter int          DB_CYCLES = 1000000,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0080
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        btnL,
    input  logic        btnR,
    input  logic [15:0] switch,
    input  logic [31:0] dataAdr,
    input  logic        writeEN,
    input  logic [31:0] writeData,
    output logic [31:0] readData
`ifdef IO_IRQ_EN
    ,
    output logic        irq
`endif
);
    typedef enum logic [1:0] {IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT} state_t;
    localparam int CW = $clog2(DB_CYCLES);
    localparam logic [CW-1:0] DB_LAST = CW'(DB_CYCLES - 1);

    logic [17:0] meta_q, sync_q;
    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= {switch, btnR, btnL};
            sync_q <= meta_q;
        end

    logic [31:0] off;
    logic        in_win, clr_wr;
    assign off    = dataAdr - BASE_ADDR;
    assign in_win = off[31:4] == 28'd0;
    assign clr_wr = writeEN && in_win && off[3:2] == 2'd2;

    logic [1:0]  sticky, level;
    logic [15:0] cnt, sw;

    for (genvar b = 0; b < 2; b++) begin : g_btn
        state_t          state_q, state_d;
        logic [CW-1:0]   db_q, db_d;
        logic [7:0]      cnt_q, cnt_d;
        logic            sticky_q, sticky_d, set;
        always_ff @(posedge clk or negedge reset)
            if (!reset) begin
                state_q  <= IDLE;
                db_q     <= '0;
                cnt_q    <= '0;
                sticky_q <= 1'b0;
            end else begin
                state_q  <= state_d;
                db_q     <= db_d;
                cnt_q    <= cnt_d;
                sticky_q <= sticky_d;
            end
        // entering a wait state already counts the first agreeing sample
        always_comb begin
            state_d = state_q;
            db_d    = '0;
            set     = 1'b0;
            case (state_q)
                IDLE:         if (sync_q[b]) begin state_d = PRESS_WAIT; db_d = CW'(1); end
                PRESS_WAIT:   if (!sync_q[b]) state_d = IDLE;
                              else if (db_q == DB_LAST) begin state_d = PRESSED; set = 1'b1; end
                              else db_d = db_q + 1'b1;
                PRESSED:      if (!sync_q[b]) begin state_d = RELEASE_WAIT; db_d = CW'(1); end
                RELEASE_WAIT: if (sync_q[b]) state_d = PRESSED;
                              else if (db_q == DB_LAST) state_d = IDLE;
                              else db_d = db_q + 1'b1;
                default:      state_d = IDLE;
            endcase
            sticky_d = set | (sticky_q & ~(clr_wr & writeData[b]));
            cnt_d    = (clr_wr & writeData[b+2]) ? {7'b0, set} : cnt_q + {7'b0, set};
        end
        assign sticky[b]       = sticky_q;
        assign level[b]        = state_q == PRESSED || state_q == RELEASE_WAIT;
        assign cnt[8*b +: 8]   = cnt_q;
    end

    for (genvar j = 0; j < 16; j++) begin : g_sw
        logic [CW-1:0] c_q;
        logic          s_q;
        always_ff @(posedge clk or negedge reset)
            if (!reset) begin
                c_q <= '0;
                s_q <= 1'b0;
            end else if (sync_q[j+2] == s_q) begin
                c_q <= '0;
            end else if (c_q == DB_LAST) begin
                c_q <= '0;
                s_q <= sync_q[j+2];
            end else begin
                c_q <= c_q + 1'b1;
            end
        assign sw[j] = s_q;
    end

    logic [31:0] mask_rd;
`ifdef IO_IRQ_EN
    logic [1:0] mask_q;
    logic       irq_q;
    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            mask_q <= '0;
            irq_q  <= 1'b0;
        end else begin
            if (writeEN && in_win && off[3:2] == 2'd3) mask_q <= writeData[1:0];
            irq_q <= |(sticky & mask_q);
        end
    assign irq     = irq_q;
    assign mask_rd = {30'b0, mask_q};
`else
    assign mask_rd = '0;
`endif

    assign readData = !in_win          ? '0 :
                      off[3:2] == 2'd0 ? {16'b0, sw} :
                      off[3:2] == 2'd1 ? {8'b0, cnt, 4'b0, level, sticky} :
                      off[3:2] == 2'd3 ? mask_rd : '0;

    logic unused_bits;
    assign unused_bits = ^{writeData[31:4], off[1:0]};
endmodule

// File: tb/tb_io_input_capture.sv
// tb_io_input_capture: directed scenarios plus randomized traffic against a run-length reference model.
module tb_io_input_capture;
    localparam int          DB   = 4;
    localparam logic [31:0] BASE = 32'h80;

    logic        clk = 0, reset = 0, btnL = 0, btnR = 0, writeEN = 0;
    logic [15:0] switch = 0;
    logic [31:0] dataAdr = BASE, writeData = 0, readData;
`ifdef IO_IRQ_EN
    logic irq;
`endif

    io_input_capture #(.DB_CYCLES(DB), .BASE_ADDR(BASE)) dut (
        .clk(clk), .reset(reset), .btnL(btnL), .btnR(btnR), .switch(switch),
        .dataAdr(dataAdr), .writeEN(writeEN), .writeData(writeData), .readData(readData)
`ifdef IO_IRQ_EN
        , .irq(irq)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0;
    bit   p1[18], p2[18], lvl[18], stk[2], irq_m;
    int   run[18], cnt[2];
    bit [1:0] msk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic void model_clear();
        for (int i = 0; i < 18; i++) begin p1[i] = 0; p2[i] = 0; lvl[i] = 0; run[i] = 0; end
        stk = '{0, 0}; cnt = '{0, 0}; msk = 0; irq_m = 0;
    endfunction

    // a level flips once DB consecutive synchronized samples disagree with it
    function automatic void model_step();
        logic [17:0] raw = {switch, btnR, btnL};
        logic [31:0] off = dataAdr - BASE;
        bit wr = writeEN && off < 16;
        bit rise[2] = '{0, 0};
        irq_m = (stk[0] & msk[0]) | (stk[1] & msk[1]);
        for (int i = 0; i < 18; i++) begin
            if (p2[i] != lvl[i]) begin
                run[i]++;
                if (run[i] == DB) begin
                    lvl[i] = p2[i];
                    run[i] = 0;
                    if (i < 2 && lvl[i]) rise[i] = 1;
                end
            end else run[i] = 0;
            p2[i] = p1[i];
            p1[i] = raw[i];
        end
        for (int b = 0; b < 2; b++) begin
            bit cs = wr && off[3:2] == 2 && writeData[b];
            bit cc = wr && off[3:2] == 2 && writeData[b+2];
            stk[b] = rise[b] ? 1'b1 : cs ? 1'b0 : stk[b];
            cnt[b] = rise[b] ? (cc ? 1 : (cnt[b] + 1) % 256) : cc ? 0 : cnt[b];
        end
`ifdef IO_IRQ_EN
        if (wr && off[3:2] == 3) msk = writeData[1:0];
`endif
    endfunction

    function automatic logic [31:0] model_read(input logic [31:0] a);
        logic [31:0] off = a - BASE;
        logic [31:0] r = 0;
        if (off < 16) begin
            if (off[3:2] == 0) for (int j = 0; j < 16; j++) r[j] = lvl[j+2];
            else if (off[3:2] == 1) r = {8'h0, 8'(cnt[1]), 8'(cnt[0]), 4'h0, lvl[1], lvl[0], stk[1], stk[0]};
`ifdef IO_IRQ_EN
            else if (off[3:2] == 3) r = {30'h0, msk};
`endif
        end
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        if (!reset) model_clear(); else model_step();
        #1;
        check("rd", readData, model_read(dataAdr));
`ifdef IO_IRQ_EN
        check("irq", {31'b0, irq}, {31'b0, irq_m});
`endif
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        dataAdr = a; writeData = d; writeEN = 1;
        tick();
        writeEN = 0; dataAdr = BASE + 4;
        #1;
    endtask

    task automatic pulse_reset();
        reset = 0;
        #1;
        model_clear();
        repeat (2) tick();
        reset = 1;
    endtask

    logic [31:0] addrs[8] = '{32'h7C, 32'h80, 32'h84, 32'h88, 32'h8C, 32'h90, 32'h180, 32'h87};

    initial begin
        model_clear();
        repeat (3) tick();
        check("rst_status", readData, 32'h0);
        reset = 1;
        dataAdr = BASE + 4;
        btnR = 1; repeat (3) tick(); btnR = 0; repeat (8) tick();
        check("bounce", readData, 32'h0);
        btnL = 1; repeat (5) tick();
        check("press_e5", readData, 32'h0);
        tick();
        check("press_e6", readData, 32'h105);
        repeat (4) tick(); btnL = 0; repeat (8) tick();
        switch = 16'hA5A5; dataAdr = BASE; repeat (6) tick();
        check("sw", readData, 32'hA5A5);
        dataAdr = 32'h90; #1; check("oob", readData, 32'h0);
        dataAdr = 32'h83; #1; check("lowbits", readData, 32'hA5A5);
        wr(BASE + 8, 32'hF);
        repeat (256) begin btnL = 1; repeat (7) tick(); btnL = 0; repeat (7) tick(); end
        check("wrap", readData, 32'h1);
        wr(BASE + 8, 32'h1);
        check("clr", readData, 32'h0);
        btnL = 1; repeat (4) tick();
        reset = 0; #1; model_clear();
        check("rst_mid", readData, 32'h0);
        dataAdr = BASE; #1; check("rst_sw", readData, 32'h0);
        dataAdr = BASE + 4;
        repeat (2) tick();
        reset = 1;
        wr(BASE + 12, 32'h1);
        repeat (4) tick();
        check("redetect_e5", {31'b0, readData[0]}, 32'h0);
        tick();
        check("redetect_e6", {31'b0, readData[0]}, 32'h1);
`ifdef IO_IRQ_EN
        tick();
        check("irq_on", {31'b0, irq}, 32'h1);
`endif
        btnL = 0; pulse_reset(); btnL = 1;
        repeat (5) tick();
        wr(BASE + 8, 32'h1);
        check("set_wins", readData, 32'h105);
        repeat (4) tick(); btnL = 0; repeat (7) tick();
        btnL = 1; repeat (7) tick(); btnL = 0; repeat (7) tick();
        btnL = 1; repeat (5) tick();
        wr(BASE + 8, 32'h5);
        check("set_wins_cnt", readData, 32'h105);
        repeat (3000) begin
            if ($urandom_range(0, 11) == 0) btnL = ~btnL;
            if ($urandom_range(0, 11) == 0) btnR = ~btnR;
            if ($urandom_range(0, 15) == 0) switch[$urandom_range(0, 15)] ^= 1'b1;
            dataAdr = addrs[$urandom_range(0, 7)];
            writeEN = $urandom_range(0, 7) == 0;
            writeData = $urandom;
            tick();
        end
        writeEN = 0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
